// File: rtl/slm_bank_gen_unisim.sv
// Shared-local-memory bank built from a 2-D array of 2048x8-class BRAM tiles.
// Optional post-reset zero-fill scrub FSM enabled by defining SLM_BANK_INIT_EN.

module slm_bank_tile #(
  parameter int DEPTH_LOG2 = 11,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  ce0,
  input  logic                  we0,
  input  logic [DEPTH_LOG2-1:0] a0,
  input  logic [WIDTH-1:0]      d0,
  input  logic [WIDTH-1:0]      wem0,
  input  logic                  ce1,
  input  logic [DEPTH_LOG2-1:0] a1,
  output logic [WIDTH-1:0]      q1
);
  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (ce0 && we0) mem[a0] <= (d0 & wem0) | (mem[a0] & ~wem0);
  end

  // Read-first: a same-edge write is not visible here; the bank forwards it instead.
  always_ff @(posedge clk) begin
    if (ce1) q1 <= mem[a1];
  end
endmodule

module slm_bank_gen_unisim #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 19,
  parameter int TILE_DEPTH_LOG2 = 11,
  parameter int TILE_WIDTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE0,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic                  WE0,
  input  logic [DATA_WIDTH-1:0] WEM0,
  input  logic                  CE1,
  input  logic [ADDR_WIDTH-1:0] A1,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic                  Q1_VALID,
  output logic                  INIT_DONE
);
  localparam int ROW_BITS = ADDR_WIDTH - TILE_DEPTH_LOG2;
  localparam int NV       = 1 << ROW_BITS;
  localparam int NH       = (DATA_WIDTH + TILE_WIDTH - 1) / TILE_WIDTH;
  localparam int PW       = NH * TILE_WIDTH;

  logic                       ready;
  logic                       scrub;
  logic [TILE_DEPTH_LOG2-1:0] scrub_cnt;

`ifdef SLM_BANK_INIT_EN
  typedef enum logic {INIT, READY} state_t;
  localparam logic [TILE_DEPTH_LOG2-1:0] CNT_ONE = 1;

  state_t                     state, state_n;
  logic [TILE_DEPTH_LOG2-1:0] scrub_cnt_n;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= INIT;
      scrub_cnt <= '0;
    end else begin
      state     <= state_n;
      scrub_cnt <= scrub_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    scrub_cnt_n = scrub_cnt;
    scrub       = 1'b0;
    if (state == INIT) begin
      scrub       = 1'b1;
      scrub_cnt_n = scrub_cnt + CNT_ONE;
      if (&scrub_cnt) state_n = READY;
    end
  end

  assign ready = (state == READY);
`else
  assign ready     = 1'b1;
  assign scrub     = 1'b0;
  assign scrub_cnt = '0;
`endif

  assign INIT_DONE = ready;

  logic                wr_acc, rd_acc, collide;
  logic [ROW_BITS-1:0] row0, row1;

  assign wr_acc  = ready & CE0 & WE0;
  assign rd_acc  = ready & CE1;
  assign collide = wr_acc & rd_acc & (A0 == A1);
  assign row0    = A0[ADDR_WIDTH-1:TILE_DEPTH_LOG2];
  assign row1    = A1[ADDR_WIDTH-1:TILE_DEPTH_LOG2];

  // Padding bits of the partial last column are written 0 but never enable a tile.
  logic [PW-1:0] d_ext, m_ext, m_any;
  always_comb begin
    d_ext = '0;
    m_ext = '1;
    m_any = '0;
    d_ext[DATA_WIDTH-1:0] = D0;
    m_ext[DATA_WIDTH-1:0] = WEM0;
    m_any[DATA_WIDTH-1:0] = WEM0;
    if (scrub) begin
      d_ext = '0;
      m_ext = '1;
      m_any = '1;
    end
  end

  logic [PW-1:0] q_rows [NV];

  for (genvar v = 0; v < NV; v++) begin : g_row
    logic          row_we, row_re;
    logic [PW-1:0] row_q;

    assign row_we   = scrub | (wr_acc & (row0 == ROW_BITS'(v)));
    assign row_re   = rd_acc & (row1 == ROW_BITS'(v));
    assign q_rows[v] = row_q;

    for (genvar h = 0; h < NH; h++) begin : g_col
      logic                       t_we;
      logic [TILE_DEPTH_LOG2-1:0] t_a0, t_a1;
      logic [TILE_WIDTH-1:0]      t_d, t_m;

      always_comb begin
        t_we = row_we & (|m_any[h*TILE_WIDTH +: TILE_WIDTH]);
        t_a0 = '0;
        t_d  = '0;
        t_m  = '0;
        if (row_we) begin
          t_a0 = scrub ? scrub_cnt : A0[TILE_DEPTH_LOG2-1:0];
          t_d  = d_ext[h*TILE_WIDTH +: TILE_WIDTH];
          t_m  = m_ext[h*TILE_WIDTH +: TILE_WIDTH];
        end
        t_a1 = row_re ? A1[TILE_DEPTH_LOG2-1:0] : '0;
      end

      slm_bank_tile #(
        .DEPTH_LOG2 (TILE_DEPTH_LOG2),
        .WIDTH      (TILE_WIDTH)
      ) u_tile (
        .clk  (CLK),
        .ce0  (row_we),
        .we0  (t_we),
        .a0   (t_a0),
        .d0   (t_d),
        .wem0 (t_m),
        .ce1  (row_re),
        .a1   (t_a1),
        .q1   (row_q[h*TILE_WIDTH +: TILE_WIDTH])
      );
    end
  end

  logic [ROW_BITS-1:0]   rsel;
  logic                  fwd, rd_seen;
  logic [DATA_WIDTH-1:0] fwd_d, fwd_m;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsel     <= '0;
      fwd      <= 1'b0;
      fwd_d    <= '0;
      fwd_m    <= '0;
      rd_seen  <= 1'b0;
      Q1_VALID <= 1'b0;
    end else begin
      Q1_VALID <= rd_acc;
      if (rd_acc) begin
        rsel    <= row1;
        rd_seen <= 1'b1;
        fwd     <= collide;
        if (collide) begin
          fwd_d <= D0;
          fwd_m <= WEM0;
        end
      end
    end
  end

  // Merge forwarded write data over the read-first tile output on a collision.
  logic [PW-1:0] tile_q;
  always_comb begin
    tile_q = q_rows[rsel];
    Q1     = '0;
    if (rd_seen) begin
      if (fwd) Q1 = (fwd_d & fwd_m) | (tile_q[DATA_WIDTH-1:0] & ~fwd_m);
      else     Q1 = tile_q[DATA_WIDTH-1:0];
    end
  end
endmodule
